// File: rtl/acc_pixel_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | acc_pixel_map                                                            |
// | Streams an image through a per-lane pixel operation, memory to memory.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module acc_pixel_map #(
    parameter int IMG_W     = 352,
    parameter int IMG_H     = 288,
    parameter int PIX_BITS  = 8,
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 16,
    parameter int N_WORDS   = IMG_W * IMG_H * PIX_BITS / WORD_BITS,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = N_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [PIX_BITS-1:0]  thr,
    output logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_BITS-1:0] dataR,
    output logic [WORD_BITS-1:0] dataW,
    output logic                 en,
    output logic                 we,
    output logic                 busy,
    output logic                 finish
);

    localparam int c_cnt_w = $clog2(N_WORDS + 1);
    localparam int c_lanes = WORD_BITS / PIX_BITS;
    localparam logic [c_cnt_w-1:0]  c_last    = c_cnt_w'(N_WORDS);
    localparam logic [c_cnt_w-1:0]  c_one     = c_cnt_w'(1);
    localparam logic [PIX_BITS-1:0] c_pix_max = '1;
    localparam logic [1:0] c_mode_invert = 2'd0;
    localparam logic [1:0] c_mode_thresh = 2'd1;
    localparam logic [1:0] c_mode_copy   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_CAP     = 3'd2,
        S_WR      = 3'd3,
        S_DRAIN   = 3'd4,
        S_WR_LAST = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_rd_cnt;
    logic [c_cnt_w-1:0]   r_wr_cnt;
    logic [WORD_BITS-1:0] r_in;
    logic [WORD_BITS-1:0] r_out;
    logic [1:0]           r_mode;
    logic [PIX_BITS-1:0]  r_thr;
    logic [WORD_BITS-1:0] w_f;
    logic                 w_latch;
    logic                 w_rd_inc;
    logic                 w_wr_inc;
    logic                 w_cap;
    logic                 w_clr;

    // Lanes are computed in isolation so no carry can leak between pixels.
    for (genvar j = 0; j < c_lanes; j++) begin : g_lane
        logic [PIX_BITS-1:0] w_pix;
        logic [PIX_BITS:0]   w_sum;
        logic [PIX_BITS-1:0] w_res;

        assign w_pix = r_in[j*PIX_BITS +: PIX_BITS];
        assign w_sum = {1'b0, w_pix} + {1'b0, r_thr};

        always_comb begin
            w_res = w_pix;
            case (r_mode)
                c_mode_invert: w_res = c_pix_max - w_pix;
                c_mode_thresh: w_res = (w_pix >= r_thr) ? c_pix_max : '0;
                c_mode_copy:   w_res = w_pix;
                default:       w_res = w_sum[PIX_BITS] ? c_pix_max : w_sum[PIX_BITS-1:0];
            endcase
        end

        assign w_f[j*PIX_BITS +: PIX_BITS] = w_res;
    end

    always_comb begin
        w_state_nxt = r_state;
        en          = 1'b0;
        we          = 1'b0;
        busy        = 1'b1;
        finish      = 1'b0;
        w_latch     = 1'b0;
        w_rd_inc    = 1'b0;
        w_wr_inc    = 1'b0;
        w_cap       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_RD;
                    w_latch     = 1'b1;
                end
            end
            S_RD: begin
                en          = 1'b1;
                w_rd_inc    = 1'b1;
                w_state_nxt = (r_rd_cnt == '0) ? S_CAP : S_WR;
            end
            S_CAP: begin
                w_cap       = 1'b1;
                w_state_nxt = (r_rd_cnt == c_last) ? S_DRAIN : S_RD;
            end
            S_WR: begin
                en          = 1'b1;
                we          = 1'b1;
                w_cap       = 1'b1;
                w_wr_inc    = 1'b1;
                w_state_nxt = (r_rd_cnt == c_last) ? S_DRAIN : S_RD;
            end
            S_DRAIN: begin
                w_state_nxt = S_WR_LAST;
            end
            S_WR_LAST: begin
                en          = 1'b1;
                we          = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b0;
                finish = 1'b1;
                w_clr  = 1'b1;
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_in     <= '0;
            r_out    <= '0;
            r_mode   <= '0;
            r_thr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_f;
            if (w_latch) begin
                r_mode <= mode;
                r_thr  <= thr;
            end
            if (w_cap) begin
                r_in <= dataR;
            end
            if (w_clr) begin
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end else begin
                if (w_rd_inc) r_rd_cnt <= r_rd_cnt + c_one;
                if (w_wr_inc) r_wr_cnt <= r_wr_cnt + c_one;
            end
        end
    end

    assign addr  = we ? (ADDR_BITS'(DST_BASE) + ADDR_BITS'(r_wr_cnt))
                      : (ADDR_BITS'(SRC_BASE) + ADDR_BITS'(r_rd_cnt));
    assign dataW = r_out;

endmodule
`default_nettype wire

// File: tb/tb_acc_pixel_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_acc_pixel_map                                                         |
// | Scoreboard bench: a 2-word image instance and a full-size instance.      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_acc_pixel_map;

    localparam int c_nb = 25344;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pix_model(input logic [1:0] m, input logic [7:0] t,
                                              input logic [31:0] w);
        logic [31:0] r;
        int p;
        int q;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            p = int'(w[j*8 +: 8]);
            case (m)
                2'd0:    q = 255 - p;
                2'd1:    q = (p >= int'(t)) ? 255 : 0;
                2'd2:    q = p;
                default: q = (p + int'(t) > 255) ? 255 : p + int'(t);
            endcase
            r[j*8 +: 8] = q[7:0];
        end
        return r;
    endfunction

    // Small instance: 4x2 image, two words, destination at word 2
    logic        rst_s = 1'b1, start_s = 1'b0;
    logic [1:0]  mode_s = '0;
    logic [7:0]  thr_s = '0;
    logic [15:0] addr_s;
    logic [31:0] dataR_s = '0, dataW_s;
    logic        en_s, we_s, busy_s, finish_s;
    logic [31:0] mem_s [0:3];
    exp_t        q_s [$];
    int          wr_cnt_s = 0;

    acc_pixel_map #(.IMG_W(4), .IMG_H(2)) u_small (
        .clk(clk), .reset(rst_s), .start(start_s), .mode(mode_s), .thr(thr_s),
        .addr(addr_s), .dataR(dataR_s), .dataW(dataW_s), .en(en_s), .we(we_s),
        .busy(busy_s), .finish(finish_s)
    );

    // Full-size instance with default parameters
    logic        rst_b = 1'b1, start_b = 1'b0;
    logic [1:0]  mode_b = '0;
    logic [7:0]  thr_b = '0;
    logic [15:0] addr_b;
    logic [31:0] dataR_b = '0, dataW_b;
    logic        en_b, we_b, busy_b, finish_b;
    logic [31:0] mem_b [0:65535];
    exp_t        q_b [$];
    int          wr_cnt_b = 0;

    acc_pixel_map u_big (
        .clk(clk), .reset(rst_b), .start(start_b), .mode(mode_b), .thr(thr_b),
        .addr(addr_b), .dataR(dataR_b), .dataW(dataW_b), .en(en_b), .we(we_b),
        .busy(busy_b), .finish(finish_b)
    );

    always @(posedge clk) begin
        if (en_s === 1'b1) begin
            if (we_s) mem_s[addr_s[1:0]] <= dataW_s;
            else      dataR_s <= mem_s[addr_s[1:0]];
        end
        if (en_b === 1'b1) begin
            if (we_b) mem_b[addr_b] <= dataW_b;
            else      dataR_b <= mem_b[addr_b];
        end
    end

    // Write monitors pop the scoreboard; a write with nothing pending is an error
    always @(negedge clk) begin
        exp_t e;
        if (en_s === 1'b1 && we_s === 1'b1) begin
            wr_cnt_s++;
            if (q_s.size() == 0) check("s_unexpected_wr", 32'd1, 32'd0);
            else begin
                e = q_s.pop_front();
                check("s_wr_addr", 32'(addr_s), 32'(e.a));
                check("s_wr_data", dataW_s, e.d);
            end
        end
        if (en_b === 1'b1 && we_b === 1'b1) begin
            wr_cnt_b++;
            if (q_b.size() == 0) check("b_unexpected_wr", 32'd1, 32'd0);
            else begin
                e = q_b.pop_front();
                check("b_wr_addr", 32'(addr_b), 32'(e.a));
                check("b_wr_data", dataW_b, e.d);
            end
        end
    end

    function automatic logic [5:0] trace_exp(input int k);
        case (k)
            1:       return 6'b10_0000;
            3:       return 6'b10_0001;
            4:       return 6'b11_0010;
            6:       return 6'b11_0011;
            default: return 6'b00_0000;
        endcase
    endfunction

    task automatic run_small(input logic [1:0] m, input logic [7:0] t,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic hold);
        exp_t x;
        int   lat;
        logic [5:0] tv;
        mem_s[0] = w0;
        mem_s[1] = w1;
        mode_s   = m;
        thr_s    = t;
        x.a = 16'd2; x.d = e0; q_s.push_back(x);
        x.a = 16'd3; x.d = e1; q_s.push_back(x);
        start_s = 1'b1;
        lat = 0;
        while (finish_s !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !hold) start_s = 1'b0;
            // Inputs scrambled mid-job must not disturb the result
            if (lat == 2) begin
                mode_s = ~m;
                thr_s  = ~t;
            end
            tv = (en_s === 1'b1) ? {en_s, we_s, addr_s[3:0]} : 6'b0;
            check("s_trace", 32'(tv), 32'(trace_exp(lat)));
        end
        check("s_finish_latency", 32'(lat), 32'd7);
        check("s_queue_empty", 32'(q_s.size()), 32'd0);
        if (!hold) begin
            @(negedge clk);
            check("s_idle_busy", 32'(busy_s), 32'd0);
            check("s_idle_finish", 32'(finish_s), 32'd0);
        end
    endtask

    initial begin
        exp_t x;
        int   k, w, t0, t1, nrd, nwr, errs;
        logic seen;

        repeat (2) @(negedge clk);
        check("s_rst_en", 32'(en_s), 32'd0);
        check("s_rst_we", 32'(we_s), 32'd0);
        check("s_rst_busy", 32'(busy_s), 32'd0);
        check("s_rst_finish", 32'(finish_s), 32'd0);
        check("s_rst_dataW", dataW_s, 32'd0);
        check("s_rst_addr", 32'(addr_s), 32'd0);
        check("b_rst_en", 32'(en_b), 32'd0);
        check("b_rst_dataW", dataW_b, 32'd0);
        check("b_rst_addr", 32'(addr_b), 32'd0);
        rst_s = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        run_small(2'd0, 8'h00, 32'h00FF7F10, 32'h12345678, 32'hFF0080EF, 32'hEDCBA987, 1'b0);
        run_small(2'd1, 8'h80, 32'h00FF7F80, 32'h7F80FF01, 32'h00FF00FF,
                  pix_model(2'd1, 8'h80, 32'h7F80FF01), 1'b0);
        run_small(2'd3, 8'h20, 32'h10F0E0FF, 32'h00DF0102, 32'h30FFFFFF,
                  pix_model(2'd3, 8'h20, 32'h00DF0102), 1'b0);
        run_small(2'd2, 8'h55, 32'hDEADBEEF, 32'h0BADF00D, 32'hDEADBEEF, 32'h0BADF00D, 1'b0);

        // start held through DONE: no retrigger until it drops
        run_small(2'd3, 8'hF0, 32'h0F10F1FF, 32'h01020304,
                  pix_model(2'd3, 8'hF0, 32'h0F10F1FF), pix_model(2'd3, 8'hF0, 32'h01020304), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s_hold_finish", 32'(finish_s), 32'd1);
            check("s_hold_en", 32'(en_s), 32'd0);
        end
        start_s = 1'b0;
        @(negedge clk);
        check("s_drop_finish", 32'(finish_s), 32'd0);
        check("s_drop_busy", 32'(busy_s), 32'd0);
        run_small(2'd0, 8'h00, 32'hA5A5A5A5, 32'h00000000, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0);

        // Full-size image: abandon a job at word 100, then run one to completion
        for (int i = 0; i < c_nb; i++) mem_b[i] = i * 32'h9E3779B1 + 32'h01234567;
        for (int i = 0; i < c_nb; i++) begin
            x.a = 16'(c_nb + i);
            x.d = pix_model(2'd0, 8'h00, mem_b[i]);
            q_b.push_back(x);
        end
        start_b = 1'b1;
        k = 0;
        while (!(en_b === 1'b1 && we_b === 1'b1 && addr_b == 16'(c_nb + 100)) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("b_reached_w100", 32'(k < 1000), 32'd1);
        rst_b   = 1'b1;
        start_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        check("b_midrst_en", 32'(en_b), 32'd0);
        check("b_midrst_busy", 32'(busy_b), 32'd0);
        check("b_midrst_finish", 32'(finish_b), 32'd0);
        check("b_midrst_dataW", dataW_b, 32'd0);
        w = wr_cnt_b;
        q_b.delete();
        repeat (20) @(negedge clk);
        check("b_no_wr_after_rst", 32'(wr_cnt_b), 32'(w));

        for (int i = 0; i < c_nb; i++) mem_b[c_nb + i] = '0;
        for (int i = 0; i < c_nb; i++) begin
            x.a = 16'(c_nb + i);
            x.d = pix_model(2'd0, 8'h00, mem_b[i]);
            q_b.push_back(x);
        end
        start_b = 1'b1;
        k = 0; t0 = 0; t1 = 0; nrd = 0; nwr = 0; seen = 1'b0;
        while (finish_b !== 1'b1 && k < 60000) begin
            @(negedge clk);
            k++;
            if (k == 1) start_b = 1'b0;
            if (en_b === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    t0   = cyc;
                    check("b_first_rd_addr", 32'(addr_b), 32'd0);
                end
                if (we_b) nwr++;
                else      nrd++;
            end
        end
        t1 = cyc;
        check("b_finish", 32'(finish_b), 32'd1);
        check("b_job_cycles", 32'(t1 - t0), 32'(2 * c_nb + 2));
        check("b_reads", 32'(nrd), 32'(c_nb));
        check("b_writes", 32'(nwr), 32'(c_nb));
        check("b_queue_empty", 32'(q_b.size()), 32'd0);
        errs = 0;
        for (int i = 0; i < c_nb; i++)
            if (mem_b[c_nb + i] !== pix_model(2'd0, 8'h00, mem_b[i])) errs++;
        check("b_dst_words_bad", 32'(errs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
